regfile_rename_fwd: RTL and testbench
=====================================

Name: regfile_rename_fwd

Overview:
- Parametrised architectural register file with a rename (busy/tag) table, for the Tomasulo core.
- Sits between decoder/issue and the RS/LSB, and supplies operand value or producer ROB tag for rs1/rs2.
- Extends the previous generation with:
  - parametrised width, depth and CDB count;
  - same-cycle CDB and commit forwarding into the operand outputs;
  - a correct priority when issue and commit target the same register;
  - a registered busy-count output.

Parameters:
- XLEN, 32, data width.
- REG_NUM, 32, architectural registers; power of 2; register 0 hardwired zero.
- RIDX_W, 6, register index width; equals log2(REG_NUM)+1. Index with MSB set = "no register" (NULL).
- ENTRY_WIDTH, 4, ROB tag width. Tag 0 = ENTRY_NULL; valid tags are 1..2^ENTRY_WIDTH-1.
- NUM_CDB, 2, number of broadcast buses (port 0 = RS ALU, port 1 = LSB).

Ports:
- clk  in  1  clock.
- rst_in  in  1  synchronous active-high reset.
- rdy_in  in  1  global enable; low = state frozen.
- roll_back  in  1  mispredict flush.
- rob_commit  in  1  commit valid.
- rob_entry  in  ENTRY_WIDTH  tag of committing entry.
- rob_des  in  RIDX_W  destination register of commit.
- rob_result  in  XLEN  commit value.
- cdb_valid  in  NUM_CDB  per-bus broadcast valid.
- cdb_entry  in  NUM_CDB*ENTRY_WIDTH  packed tags; bus k at [k*ENTRY_WIDTH +: ENTRY_WIDTH].
- cdb_result  in  NUM_CDB*XLEN  packed results.
- new_issue  in  1  instruction issued this cycle.
- rob_new_entry  in  ENTRY_WIDTH  tag allocated to the issuing instruction.
- rs1_in, rs2_in, rd_in  in  RIDX_W  decoded register indices.
- Qj, Qk  out  ENTRY_WIDTH  producer tag; ENTRY_NULL = value ready.
- Vj, Vk  out  XLEN  operand value; 0 when Q is non-null.
- busy_count  out  log2(REG_NUM)+1  number of busy registers, registered.

Behaviour:
- **State:** value[REG_NUM], tag[REG_NUM], busy[REG_NUM].
- **Reset** (rst_in=1 at posedge; overrides rdy_in and every other input):
  - all value=0, tag=ENTRY_NULL, busy=0, busy_count=0.
- **Read path** (combinational, evaluated independently for rs1→(Qj,Vj) and rs2→(Qk,Vk)). Priority:
  1. Index NULL or 0 → Q=NULL, V=0.
  2. !busy → Q=NULL, V=value[idx].
  3. busy, and some k has cdb_valid[k] with cdb_entry[k]==tag[idx] → Q=NULL, V=cdb_result[k]. Lowest k wins; tags are unique, so collision is not expected.
  4. busy, and rob_commit with rob_entry==tag[idx] → Q=NULL, V=rob_result.
  5. Otherwise Q=tag[idx], V=0.
- **Rename timing:** reads see the pre-issue state. An instruction whose rd equals its own rs1 gets the old producer, not its own tag.
- **Freeze:** rdy_in=0 → no state change; read outputs still track inputs.
- **roll_back=1** (rdy_in=1):
  - every busy←0, tag←NULL; busy_count←0.
  - new_issue is ignored.
  - If rob_commit with rob_des non-NULL and non-zero, value[rob_des]←rob_result in the same cycle.
- **Normal cycle** (rdy_in=1, roll_back=0):
  - Issue: new_issue and rd_in non-NULL and non-zero → tag[rd_in]←rob_new_entry, busy[rd_in]←1.
  - Commit: rob_commit and rob_des non-NULL and non-zero → value[rob_des]←rob_result.
  - Commit clears busy[rob_des] and sets tag←NULL only if tag[rob_des]==rob_entry AND the register is not renamed by an issue in the same cycle. Issue wins.
  - Register 0: value stays 0, busy stays 0, always.
- **busy_count:** registered; equals the popcount of the next-state busy vector. Range 0..REG_NUM-1, because x0 is never busy.
- **CDB data:** the CDB does not write the register file. Only commit updates value.

Test Plan:
- Reset, then read rs1=5, rs2=NULL → Qj=0, Vj=0, Qk=0, Vk=0, busy_count=0.
- Issue rd=5 tag 3. Next cycle read rs1=5 → Qj=3, Vj=0, busy_count=1. Same cycle cdb_valid[1]=1, entry 3, result 0xDEADBEEF → Qj=0, Vj=0xDEADBEEF.
- Commit des=5, entry 3, result 0x11 → value[5]=0x11, busy cleared, busy_count=0. Then read rs1=5 → Qj=0, Vj=0x11.
- Issue rd=7 tag 2, then tag 4. Commit des=7, entry 2 → value[7] updated; busy remains, Qj=4. Same-cycle test: commit des=7, entry 4 together with issue rd=7 tag 6 → busy[7]=1, tag 6.
- Issue rd=0 tag 1 → no rename, busy_count unchanged. Commit des=0 result 0x55 → read x0 gives V=0.
- Rename regs 1, 2, 3, then roll_back with commit des=2 result 0x99 → all Q=NULL, value[2]=0x99, busy_count=0. Repeat with rdy_in=0 → nothing changes.

Source files
------------

// File: rtl/regfile_rename_fwd_if.sv
// Issue/commit/CDB bundle between the decoder, ROB, CDBs and the rename register file.
// The register file takes the slave side.
interface regfile_rename_fwd_if #(
    parameter int XLEN        = 32,
    parameter int REG_NUM     = 32,
    parameter int RIDX_W      = 6,
    parameter int ENTRY_WIDTH = 4,
    parameter int NUM_CDB     = 2
);
    logic                          rdy_in;
    logic                          roll_back;
    logic                          rob_commit;
    logic [ENTRY_WIDTH-1:0]        rob_entry;
    logic [RIDX_W-1:0]             rob_des;
    logic [XLEN-1:0]               rob_result;
    logic [NUM_CDB-1:0]            cdb_valid;
    logic [NUM_CDB*ENTRY_WIDTH-1:0] cdb_entry;
    logic [NUM_CDB*XLEN-1:0]       cdb_result;
    logic                          new_issue;
    logic [ENTRY_WIDTH-1:0]        rob_new_entry;
    logic [RIDX_W-1:0]             rs1_in;
    logic [RIDX_W-1:0]             rs2_in;
    logic [RIDX_W-1:0]             rd_in;
    logic [ENTRY_WIDTH-1:0]        Qj;
    logic [ENTRY_WIDTH-1:0]        Qk;
    logic [XLEN-1:0]               Vj;
    logic [XLEN-1:0]               Vk;
    logic [$clog2(REG_NUM):0]      busy_count;

    modport master (
        output rdy_in, roll_back, rob_commit, rob_entry, rob_des, rob_result,
               cdb_valid, cdb_entry, cdb_result, new_issue, rob_new_entry,
               rs1_in, rs2_in, rd_in,
        input  Qj, Qk, Vj, Vk, busy_count
    );

    modport slave (
        input  rdy_in, roll_back, rob_commit, rob_entry, rob_des, rob_result,
               cdb_valid, cdb_entry, cdb_result, new_issue, rob_new_entry,
               rs1_in, rs2_in, rd_in,
        output Qj, Qk, Vj, Vk, busy_count
    );
endinterface

// File: rtl/regfile_rename_fwd.sv
// Architectural register file with busy/tag rename table and same-cycle CDB/commit
// forwarding on the two operand read ports.
module regfile_rename_fwd #(
    parameter int XLEN        = 32,
    parameter int REG_NUM     = 32,
    parameter int RIDX_W      = 6,
    parameter int ENTRY_WIDTH = 4,
    parameter int NUM_CDB     = 2
) (
    input logic clk,
    input logic rst_in,
    regfile_rename_fwd_if.slave bus
);
    localparam int REG_W = $clog2(REG_NUM);
    localparam int CNT_W = REG_W + 1;

    typedef struct packed {
        logic [ENTRY_WIDTH-1:0] q;
        logic [XLEN-1:0]        v;
    } operand_t;

    logic [XLEN-1:0]        value [REG_NUM];
    logic [ENTRY_WIDTH-1:0] tag   [REG_NUM];
    logic [REG_NUM-1:0]     busy;
    logic [REG_NUM-1:0]     busy_nxt;
    logic [CNT_W-1:0]       busy_count;

    logic [REG_W-1:0] rd_reg;
    logic [REG_W-1:0] des_reg;
    logic             issue_ok;
    logic             commit_ok;
    logic             commit_clear;
    operand_t         op1;
    operand_t         op2;

    function automatic logic [CNT_W-1:0] popcount(input logic [REG_NUM-1:0] vec);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            cnt = cnt + CNT_W'(vec[i]);
        end
        return cnt;
    endfunction

    // Reads see pre-issue state; a waiting operand picks up a result broadcast or
    // committed in the same cycle so the RS never misses it.
    function automatic operand_t read_operand(input logic [RIDX_W-1:0] idx);
        operand_t         op;
        logic [REG_W-1:0] r;
        logic             hit;
        op  = '0;
        r   = idx[REG_W-1:0];
        hit = 1'b0;
        if (!idx[RIDX_W-1] && r != '0) begin
            if (!busy[r]) begin
                op.v = value[r];
            end else begin
                for (int k = 0; k < NUM_CDB; k++) begin
                    if (!hit && bus.cdb_valid[k] &&
                        bus.cdb_entry[k*ENTRY_WIDTH +: ENTRY_WIDTH] == tag[r]) begin
                        hit  = 1'b1;
                        op.v = bus.cdb_result[k*XLEN +: XLEN];
                    end
                end
                if (!hit) begin
                    if (bus.rob_commit && bus.rob_entry == tag[r]) begin
                        op.v = bus.rob_result;
                    end else begin
                        op.q = tag[r];
                    end
                end
            end
        end
        return op;
    endfunction

    always_comb begin
        op1 = read_operand(bus.rs1_in);
        op2 = read_operand(bus.rs2_in);
    end

    assign bus.Qj         = op1.q;
    assign bus.Vj         = op1.v;
    assign bus.Qk         = op2.q;
    assign bus.Vk         = op2.v;
    assign bus.busy_count = busy_count;

    assign rd_reg    = bus.rd_in[REG_W-1:0];
    assign des_reg   = bus.rob_des[REG_W-1:0];
    assign issue_ok  = bus.new_issue && !bus.rd_in[RIDX_W-1] && rd_reg != '0;
    assign commit_ok = bus.rob_commit && !bus.rob_des[RIDX_W-1] && des_reg != '0;
    // A rename of the same register in this cycle keeps it busy under the new tag.
    assign commit_clear = commit_ok && tag[des_reg] == bus.rob_entry &&
                          !(issue_ok && rd_reg == des_reg);

    always_comb begin
        busy_nxt = busy;
        if (bus.roll_back) begin
            busy_nxt = '0;
        end else begin
            if (commit_clear) busy_nxt[des_reg] = 1'b0;
            if (issue_ok)     busy_nxt[rd_reg]  = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                value[i] <= '0;
                tag[i]   <= '0;
            end
            busy       <= '0;
            busy_count <= '0;
        end else if (bus.rdy_in) begin
            busy       <= busy_nxt;
            busy_count <= popcount(busy_nxt);
            if (commit_ok) value[des_reg] <= bus.rob_result;
            if (bus.roll_back) begin
                for (int i = 0; i < REG_NUM; i++) begin
                    tag[i] <= '0;
                end
            end else begin
                if (commit_clear) tag[des_reg] <= '0;
                if (issue_ok)     tag[rd_reg]  <= bus.rob_new_entry;
            end
        end
    end
endmodule

// File: tb/tb_regfile_rename_fwd.sv
// Directed bench for regfile_rename_fwd: rename, forwarding, commit/issue priority,
// x0 handling, roll-back and freeze.
module tb_regfile_rename_fwd;
    localparam logic [5:0] RNULL = 6'h20;

    logic clk;
    logic rst_in;
    int   checks;
    int   errors;

    regfile_rename_fwd_if #(.XLEN(32), .REG_NUM(32), .RIDX_W(6), .ENTRY_WIDTH(4), .NUM_CDB(2)) bus ();

    regfile_rename_fwd #(.XLEN(32), .REG_NUM(32), .RIDX_W(6), .ENTRY_WIDTH(4), .NUM_CDB(2)) dut (
        .clk    (clk),
        .rst_in (rst_in),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.roll_back     = 1'b0;
        bus.rob_commit    = 1'b0;
        bus.rob_entry     = '0;
        bus.rob_des       = RNULL;
        bus.rob_result    = '0;
        bus.cdb_valid     = '0;
        bus.cdb_entry     = '0;
        bus.cdb_result    = '0;
        bus.new_issue     = 1'b0;
        bus.rob_new_entry = '0;
        bus.rd_in         = RNULL;
    endtask

    task automatic issue(input logic [5:0] rd, input logic [3:0] t);
        bus.new_issue     = 1'b1;
        bus.rd_in         = rd;
        bus.rob_new_entry = t;
        tick();
        idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_in = 1'b1;
        bus.rdy_in = 1'b1;
        bus.rs1_in = RNULL;
        bus.rs2_in = RNULL;
        idle();
        tick();
        tick();
        rst_in = 1'b0;

        // Reset state
        bus.rs1_in = 6'd5;
        bus.rs2_in = RNULL;
        #1;
        check("rst_qj", 32'(bus.Qj), 32'd0);
        check("rst_vj", bus.Vj, 32'd0);
        check("rst_qk", 32'(bus.Qk), 32'd0);
        check("rst_vk", bus.Vk, 32'd0);
        check("rst_busy_count", 32'(bus.busy_count), 32'd0);

        // Rename x5 to tag 3, then CDB forwarding on bus 1
        issue(6'd5, 4'd3);
        #1;
        check("ren5_qj", 32'(bus.Qj), 32'd3);
        check("ren5_vj", bus.Vj, 32'd0);
        check("ren5_cnt", 32'(bus.busy_count), 32'd1);
        bus.cdb_valid  = 2'b10;
        bus.cdb_entry  = {4'd3, 4'd0};
        bus.cdb_result = {32'hDEADBEEF, 32'h0};
        #1;
        check("cdb1_qj", 32'(bus.Qj), 32'd0);
        check("cdb1_vj", bus.Vj, 32'hDEADBEEF);
        tick();
        idle();
        #1;
        check("cdb_nowrite_qj", 32'(bus.Qj), 32'd3);

        // Commit x5 with same-cycle forwarding
        bus.rob_commit = 1'b1;
        bus.rob_des    = 6'd5;
        bus.rob_entry  = 4'd3;
        bus.rob_result = 32'h11;
        #1;
        check("cmt_fwd_qj", 32'(bus.Qj), 32'd0);
        check("cmt_fwd_vj", bus.Vj, 32'h11);
        tick();
        idle();
        #1;
        check("cmt5_qj", 32'(bus.Qj), 32'd0);
        check("cmt5_vj", bus.Vj, 32'h11);
        check("cmt5_cnt", 32'(bus.busy_count), 32'd0);

        // Double rename of x7; stale commit must not clear busy
        bus.rs2_in = 6'd7;
        issue(6'd7, 4'd2);
        issue(6'd7, 4'd4);
        check("ren7_cnt", 32'(bus.busy_count), 32'd1);
        check("ren7_qk", 32'(bus.Qk), 32'd4);
        bus.rob_commit = 1'b1;
        bus.rob_des    = 6'd7;
        bus.rob_entry  = 4'd2;
        bus.rob_result = 32'h22;
        #1;
        check("stale_fwd_qk", 32'(bus.Qk), 32'd4);
        tick();
        idle();
        #1;
        check("stale_qk", 32'(bus.Qk), 32'd4);
        check("stale_vk", bus.Vk, 32'd0);
        check("stale_cnt", 32'(bus.busy_count), 32'd1);

        // Commit and issue on x7 in the same cycle: issue wins
        bus.rob_commit    = 1'b1;
        bus.rob_des       = 6'd7;
        bus.rob_entry     = 4'd4;
        bus.rob_result    = 32'h44;
        bus.new_issue     = 1'b1;
        bus.rd_in         = 6'd7;
        bus.rob_new_entry = 4'd6;
        #1;
        check("same_fwd_qk", 32'(bus.Qk), 32'd0);
        check("same_fwd_vk", bus.Vk, 32'h44);
        tick();
        idle();
        #1;
        check("same_qk", 32'(bus.Qk), 32'd6);
        check("same_cnt", 32'(bus.busy_count), 32'd1);

        // x0 is never renamed nor written
        bus.rs1_in = 6'd0;
        issue(6'd0, 4'd1);
        check("x0_cnt", 32'(bus.busy_count), 32'd1);
        check("x0_qj", 32'(bus.Qj), 32'd0);
        bus.rob_commit = 1'b1;
        bus.rob_des    = 6'd0;
        bus.rob_entry  = 4'd1;
        bus.rob_result = 32'h55;
        tick();
        idle();
        #1;
        check("x0_vj", bus.Vj, 32'd0);

        // Rename x1..x3, then roll back with a commit to x2 and an ignored issue to x4
        issue(6'd1, 4'd1);
        issue(6'd2, 4'd2);
        issue(6'd3, 4'd3);
        check("pre_rb_cnt", 32'(bus.busy_count), 32'd4);
        bus.rs1_in = 6'd2;
        #1;
        check("pre_rb_qj", 32'(bus.Qj), 32'd2);
        bus.roll_back     = 1'b1;
        bus.rob_commit    = 1'b1;
        bus.rob_des       = 6'd2;
        bus.rob_entry     = 4'd2;
        bus.rob_result    = 32'h99;
        bus.new_issue     = 1'b1;
        bus.rd_in         = 6'd4;
        bus.rob_new_entry = 4'd10;
        tick();
        idle();
        #1;
        check("rb_cnt", 32'(bus.busy_count), 32'd0);
        check("rb_qj", 32'(bus.Qj), 32'd0);
        check("rb_vj", bus.Vj, 32'h99);
        check("rb_qk", 32'(bus.Qk), 32'd0);
        check("rb_vk", bus.Vk, 32'h44);
        bus.rs1_in = 6'd4;
        bus.rs2_in = 6'd3;
        #1;
        check("rb_noissue_qj", 32'(bus.Qj), 32'd0);
        check("rb_x3_qk", 32'(bus.Qk), 32'd0);

        // Freeze: roll back, commit and issue all ignored while rdy_in is low
        bus.rs1_in = 6'd3;
        bus.rs2_in = 6'd2;
        issue(6'd3, 4'd5);
        check("pre_frz_cnt", 32'(bus.busy_count), 32'd1);
        bus.rdy_in        = 1'b0;
        bus.roll_back     = 1'b1;
        bus.rob_commit    = 1'b1;
        bus.rob_des       = 6'd2;
        bus.rob_entry     = 4'd5;
        bus.rob_result    = 32'h77;
        bus.new_issue     = 1'b1;
        bus.rd_in         = 6'd9;
        bus.rob_new_entry = 4'd7;
        tick();
        idle();
        #1;
        check("frz_cnt", 32'(bus.busy_count), 32'd1);
        check("frz_qj", 32'(bus.Qj), 32'd5);
        check("frz_vk", bus.Vk, 32'h99);
        bus.cdb_valid  = 2'b11;
        bus.cdb_entry  = {4'd5, 4'd5};
        bus.cdb_result = {32'hBBBB0001, 32'hAAAA0000};
        #1;
        check("frz_cdb_low_qj", 32'(bus.Qj), 32'd0);
        check("frz_cdb_low_vj", bus.Vj, 32'hAAAA0000);
        idle();
        bus.rs2_in = 6'd9;
        #1;
        check("frz_x9_qk", 32'(bus.Qk), 32'd0);

        // Reset overrides a low rdy_in
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        bus.rs2_in = 6'd2;
        #1;
        check("rst2_cnt", 32'(bus.busy_count), 32'd0);
        check("rst2_qj", 32'(bus.Qj), 32'd0);
        check("rst2_vk", bus.Vk, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
